// File: rtl/alu_wb_pkg.sv
// Shared constants for the execute/write-back sequencer: widths, opcodes and FSM encoding.
// Data words are numbered with bit 0 as the MSB, so word_t uses an ascending range.
package alu_wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 3;

  typedef logic [0:DATA_W-1] word_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_wb_ctrl_alu16.sv
// Purely combinational 16-bit ALU producing a result plus zero and carry/shift-out flags.
// Bit 0 of every word is the MSB, so the shift-out bits are a[0] (SHL) and a[DATA_W-1] (SHR).
module alu16
  import alu_wb_pkg::*;
(
  input  logic [0:DATA_W-1] a,
  input  logic [0:DATA_W-1] b,
  input  logic [OP_W-1:0]   op,
  output logic [0:DATA_W-1] y,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = '0;
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      // Carry out of A + ~B + 1 is the inverted borrow.
      OP_SUB: begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        y     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y     = a << 1;
        carry = a[0];
      end
      OP_SHR: begin
        y     = a >> 1;
        carry = a[DATA_W-1];
      end
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/alu_wb_ctrl.sv
// Four-state sequencer: accept an instruction, read operands from the register file,
// execute on alu16, then write the result back with a one-cycle done pulse.
module alu_wb_ctrl
  import alu_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [0:DATA_W-1] rf_a,
  input  logic [0:DATA_W-1] rf_b,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [0:DATA_W-1] d_in,
  output logic              done,
  output logic              zero,
  output logic              carry
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs_a_q, rs_a_d;
  logic [ADDR_W-1:0] rs_b_q, rs_b_d;
  word_t             a_q, a_d;
  word_t             b_q, b_d;
  word_t             res_q, res_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  word_t             alu_y;
  logic              alu_zero;
  logic              alu_carry;

  alu16 u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  // Every register holds unless its own state loads it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_a_d  = rs_a_q;
    rs_b_d  = rs_b_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = op;
          rd_d    = rd;
          rs_a_d  = rs_a;
          rs_b_d  = rs_b;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_y;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_a_q  <= '0;
      rs_b_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_a_q  <= rs_a_d;
      rs_b_q  <= rs_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign wr          = (state_q == S_WB);
  assign done        = (state_q == S_WB);
  assign rd_addr_a   = rs_a_q;
  assign rd_addr_b   = rs_b_q;
  assign wr_addr     = rd_q;
  assign d_in        = res_q;
  assign zero        = zero_q;
  assign carry       = carry_q;

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Bench for alu_wb_ctrl with a behavioural 8x16 register file and a scoreboard that
// checks every write-back against hand-computed results queued at issue time.
module tb_alu_wb_ctrl;
  import alu_wb_pkg::*;

  typedef struct {
    logic [2:0]  rd;
    logic [0:15] y;
    logic        z;
    logic        c;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs_a;
  logic [2:0]  rs_b;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [0:15] rf_a;
  logic [0:15] rf_b;
  logic        wr;
  logic [2:0]  wr_addr;
  logic [0:15] d_in;
  logic        done;
  logic        zero;
  logic        carry;

  logic [0:15] rf [8];
  logic [0:15] exp_rf [8];
  logic        bd_we;
  logic [2:0]  bd_addr;
  logic [0:15] bd_data;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_accept = 0;
  int   prev_accept = 0;
  int   expected_low = 3;
  int   low_cnt = 0;

  always #5 clk = ~clk;

  alu_wb_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .rd          (rd),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rf_a        (rf_a),
    .rf_b        (rf_b),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .done        (done),
    .zero        (zero),
    .carry       (carry)
  );

  // Register file: reset dominates the DUT write, which dominates the backdoor port.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr) begin
      rf[wr_addr] <= d_in;
    end else if (bd_we) begin
      rf[bd_addr] <= bd_data;
    end
  end

  assign rf_a = rf[rd_addr_a];
  assign rf_b = rf[rd_addr_b];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops one expectation per write-back and tracks the busy window length.
  always @(negedge clk) begin
    if (!instr_ready) begin
      low_cnt++;
    end else if (low_cnt != 0) begin
      checkOutput("ready_low_cycles", low_cnt, expected_low);
      low_cnt = 0;
    end
    if (done || wr) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wb", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("wb_done", done, 1);
        checkOutput("wb_wr", wr, 1);
        checkOutput("wb_addr", wr_addr, e.rd);
        checkOutput("wb_data", d_in, e.y);
        checkOutput("wb_zero", zero, e.z);
        checkOutput("wb_carry", carry, e.c);
        checkOutput("wb_latency", cyc, e.t + 3);
      end
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [0:15] val);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = idx;
    bd_data = val;
    @(negedge clk);
    bd_we   = 1'b0;
    exp_rf[idx] = val;
  endtask

  task automatic applyStimulus(input logic [2:0] op_i, input logic [2:0] rd_i,
                               input logic [2:0] rsa_i, input logic [2:0] rsb_i,
                               input logic [0:15] y_i, input logic z_i, input logic c_i,
                               input bit expect_wb, input bit hold);
    int n;
    exp_t e;
    @(negedge clk);
    op          = op_i;
    rd          = rd_i;
    rs_a        = rsa_i;
    rs_b        = rsb_i;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checkOutput("ready_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    prev_accept = last_accept;
    last_accept = cyc;
    if (expect_wb) begin
      e.rd = rd_i;
      e.y  = y_i;
      e.z  = z_i;
      e.c  = c_i;
      e.t  = cyc;
      exp_q.push_back(e);
      exp_rf[rd_i] = y_i;
    end
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) checkOutput("wb_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkReg(input logic [2:0] idx);
    checkOutput($sformatf("r%0d", idx), rf[idx], exp_rf[idx]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    // Reset held together with a valid instruction: nothing may be latched.
    reset       = 1'b1;
    instr_valid = 1'b1;
    op          = OP_ADD;
    rd          = 3'd7;
    rs_a        = 3'd5;
    rs_b        = 3'd6;
    repeat (3) @(negedge clk);
    reset       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_wr", wr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_carry", carry, 0);
    checkOutput("rst_rd_addr_a", rd_addr_a, 0);
    checkOutput("rst_rd_addr_b", rd_addr_b, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_d_in", d_in, 0);

    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    applyStimulus(OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDone();
    checkReg(3'd4);

    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    applyStimulus(OP_ADD, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(OP_SUB, 3'd6, 3'd1, 3'd1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    waitDone();
    checkReg(3'd5);
    checkReg(3'd6);

    // Reset at the edge ending EXEC of an XOR: write lost, file cleared, flags cleared.
    expected_low = 2;
    applyStimulus(OP_XOR, 3'd2, 3'd1, 3'd2, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    checkOutput("abort_ready", instr_ready, 1);
    checkOutput("abort_wr", wr, 0);
    checkOutput("abort_zero", zero, 0);
    checkOutput("abort_carry", carry, 0);
    checkOutput("abort_rd_addr_a", rd_addr_a, 0);
    checkReg(3'd2);
    checkReg(3'd4);
    @(negedge clk);
    expected_low = 3;

    preload(3'd1, 16'h8001);
    applyStimulus(OP_SHL, 3'd7, 3'd1, 3'd0, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0);
    waitDone();
    checkReg(3'd7);
    applyStimulus(OP_SHR, 3'd7, 3'd1, 3'd0, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b0);
    waitDone();
    checkReg(3'd7);

    // Back-to-back with valid held: second ADD must see the freshly written r3.
    preload(3'd1, 16'h0001);
    preload(3'd2, 16'h0002);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(OP_ADD, 3'd3, 3'd3, 3'd3, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_accept_gap", last_accept - prev_accept, 4);
    waitDone();
    checkReg(3'd3);

    // Fields changed and valid toggled while busy must be ignored.
    applyStimulus(OP_AND, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    op          = OP_OR;
    rd          = 3'd6;
    rs_a        = 3'd1;
    rs_b        = 3'd3;
    instr_valid = 1'b1;
    @(negedge clk);
    op          = OP_XOR;
    rd          = 3'd0;
    instr_valid = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    waitDone();
    checkReg(3'd5);
    checkReg(3'd6);
    checkReg(3'd0);

    applyStimulus(OP_NOT, 3'd0, 3'd2, 3'd0, 16'hFFFD, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDone();
    checkReg(3'd0);
    applyStimulus(OP_OR, 3'd6, 3'd1, 3'd3, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDone();
    checkReg(3'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
